// File: rtl/bus_request_router_pkg.sv
// Shared types and helpers for the bus request router: FSM state encoding,
// default-width request record and the grant legality check.
package bus_router_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } router_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   wdata;
    logic                    we;
    logic [DEF_DATA_W/8-1:0] be;
  } bus_req_t;

  // A grant is legal only if sel names an existing master that is requesting.
  function automatic logic legal_grant(input logic [31:0] valid,
                                       input logic [31:0] sel,
                                       input int unsigned count);
    if (sel >= count) return 1'b0;
    return valid[sel[4:0]];
  endfunction

endpackage

// File: rtl/bus_request_router_if.sv
// Master-side and slave-side bus signals of the request router. The slave
// modport is the router's view; the master modport is the surrounding system.
interface bus_request_router_if #(
  parameter int unsigned IN_COUNT = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
);
  logic [IN_COUNT-1:0]          m_req_valid_i;
  logic [IN_COUNT-1:0]          m_req_ready_o;
  logic [IN_COUNT*ADDR_W-1:0]   m_addr_i;
  logic [IN_COUNT*DATA_W-1:0]   m_wdata_i;
  logic [IN_COUNT-1:0]          m_we_i;
  logic [IN_COUNT*DATA_W/8-1:0] m_be_i;
  logic [IN_COUNT-1:0]          m_rsp_valid_o;
  logic [DATA_W-1:0]            m_rsp_rdata_o;

  logic                         s_req_valid_o;
  logic                         s_req_ready_i;
  logic [ADDR_W-1:0]            s_addr_o;
  logic [DATA_W-1:0]            s_wdata_o;
  logic                         s_we_o;
  logic [DATA_W/8-1:0]          s_be_o;
  logic                         s_rsp_valid_i;
  logic [DATA_W-1:0]            s_rsp_rdata_i;

  modport slave (
    input  m_req_valid_i, m_addr_i, m_wdata_i, m_we_i, m_be_i,
    input  s_req_ready_i, s_rsp_valid_i, s_rsp_rdata_i,
    output m_req_ready_o, m_rsp_valid_o, m_rsp_rdata_o,
    output s_req_valid_o, s_addr_o, s_wdata_o, s_we_o, s_be_o
  );

  modport master (
    output m_req_valid_i, m_addr_i, m_wdata_i, m_we_i, m_be_i,
    output s_req_ready_i, s_rsp_valid_i, s_rsp_rdata_i,
    input  m_req_ready_o, m_rsp_valid_o, m_rsp_rdata_o,
    input  s_req_valid_o, s_addr_o, s_wdata_o, s_we_o, s_be_o
  );
endinterface

// File: rtl/bus_request_router.sv
// Latches the arbiter-selected master request, presents it to the single slave
// port and routes the one response back to the owner; one transaction at a time.
module bus_request_router
  import bus_router_pkg::*;
#(
  parameter int unsigned IN_COUNT = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  bus_request_router_if.slave          bus,
  output logic [IN_COUNT-1:0]          arb_valid_list_o,
  input  logic [$clog2(IN_COUNT):0]    arb_sel_i,
  output logic                         busy_o,
  output logic [$clog2(IN_COUNT)-1:0]  owner_o,
  output logic                         err_spurious_rsp_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OWN_W = $clog2(IN_COUNT);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [BE_W-1:0]   be;
  } hold_t;

  router_state_e    state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  hold_t            hold_q, hold_d;
  logic [OWN_W-1:0] sel_idx;

  assign sel_idx = arb_sel_i[OWN_W-1:0];

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    hold_d             = hold_q;
    bus.m_req_ready_o  = '0;
    bus.m_rsp_valid_o  = '0;
    bus.m_rsp_rdata_o  = '0;
    arb_valid_list_o   = '0;
    err_spurious_rsp_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The arbiter only sees requests here so its history moves on real grants.
        arb_valid_list_o   = bus.m_req_valid_i;
        err_spurious_rsp_o = bus.s_rsp_valid_i;
        if (legal_grant(32'(bus.m_req_valid_i), 32'(arb_sel_i), IN_COUNT)) begin
          bus.m_req_ready_o[sel_idx] = 1'b1;
          owner_d      = sel_idx;
          hold_d.addr  = bus.m_addr_i[sel_idx*ADDR_W +: ADDR_W];
          hold_d.wdata = bus.m_wdata_i[sel_idx*DATA_W +: DATA_W];
          hold_d.we    = bus.m_we_i[sel_idx];
          hold_d.be    = bus.m_be_i[sel_idx*BE_W +: BE_W];
          state_d      = REQ;
        end
      end
      REQ: begin
        err_spurious_rsp_o = bus.s_rsp_valid_i;
        if (bus.s_req_ready_i) state_d = RESP;
      end
      RESP: begin
        if (bus.s_rsp_valid_i) begin
          bus.m_rsp_valid_o[owner_q] = 1'b1;
          bus.m_rsp_rdata_o          = bus.s_rsp_rdata_i;
          state_d                    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.s_req_valid_o = (state_q == REQ);
  assign bus.s_addr_o      = hold_q.addr;
  assign bus.s_wdata_o     = hold_q.wdata;
  assign bus.s_we_o        = hold_q.we;
  assign bus.s_be_o        = hold_q.be;
  assign busy_o            = (state_q != IDLE);
  assign owner_o           = owner_q;

endmodule

// File: tb/tb_bus_request_router.sv
// Scoreboard bench for bus_request_router: stimulus pushes expected grants,
// slave requests, responses and spurious flags; a monitor pops and compares.
module tb_bus_request_router;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bus_request_router_if #(.IN_COUNT(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [N-1:0] arb_valid_list_o;
  logic [1:0]   arb_sel_i;
  logic [1:0]   man_sel;
  logic [1:0]   rr_sel;
  logic         use_arb;
  logic         busy_o;
  logic [0:0]   owner_o;
  logic         err_spurious_rsp_o;
  logic         rr_last_q;
  int unsigned  rr_idx;

  bus_request_router #(.IN_COUNT(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .bus                (bus),
    .arb_valid_list_o   (arb_valid_list_o),
    .arb_sel_i          (arb_sel_i),
    .busy_o             (busy_o),
    .owner_o            (owner_o),
    .err_spurious_rsp_o (err_spurious_rsp_o)
  );

  // Round-robin arbiter standing in for interface_arbiter; sel = N means none.
  always_comb begin
    rr_sel = 2'd2;
    rr_idx = 0;
    for (int i = N; i >= 1; i--) begin
      rr_idx = (int'(rr_last_q) + i) % N;
      if (arb_valid_list_o[rr_idx]) rr_sel = 2'(rr_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) rr_last_q <= 1'b1;
    else if (|arb_valid_list_o) rr_last_q <= rr_sel[0];
  end

  assign arb_sel_i = use_arb ? rr_sel : man_sel;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [BW-1:0] be;
  } sreq_t;

  typedef struct {
    logic [N-1:0]  vec;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic [N-1:0] grant_q[$];
  sreq_t        sreq_q[$];
  rsp_t         rsp_q[$];
  logic         err_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    sreq_t s;
    rsp_t  r;
    forever begin
      @(negedge clk);
      if (bus.m_req_ready_o != '0) begin
        if (grant_q.size() == 0) chk("unexpected_grant", 64'(bus.m_req_ready_o), 64'd0);
        else chk("grant", 64'(bus.m_req_ready_o), 64'(grant_q.pop_front()));
      end
      if (bus.s_req_valid_o && bus.s_req_ready_i) begin
        if (sreq_q.size() == 0) chk("unexpected_s_handshake", 64'd1, 64'd0);
        else begin
          s = sreq_q.pop_front();
          chk("s_addr", 64'(bus.s_addr_o), 64'(s.addr));
          chk("s_wdata", 64'(bus.s_wdata_o), 64'(s.wdata));
          chk("s_we", 64'(bus.s_we_o), 64'(s.we));
          chk("s_be", 64'(bus.s_be_o), 64'(s.be));
        end
      end
      if (bus.m_rsp_valid_o != '0) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(bus.m_rsp_valid_o), 64'd0);
        else begin
          r = rsp_q.pop_front();
          chk("rsp_valid", 64'(bus.m_rsp_valid_o), 64'(r.vec));
          chk("rsp_rdata", 64'(bus.m_rsp_rdata_o), 64'(r.rdata));
        end
      end
      if (err_spurious_rsp_o) begin
        if (err_q.size() == 0) chk("unexpected_spurious", 64'd1, 64'd0);
        else chk("spurious", 64'(err_spurious_rsp_o), 64'(err_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic we, input logic [BW-1:0] be);
    bus.m_addr_i[k*AW +: AW]  = a;
    bus.m_wdata_i[k*DW +: DW] = d;
    bus.m_we_i[k]             = we;
    bus.m_be_i[k*BW +: BW]    = be;
  endtask

  initial begin : stimulus
    bus.m_req_valid_i = '0;
    bus.m_addr_i      = '0;
    bus.m_wdata_i     = '0;
    bus.m_we_i        = '0;
    bus.m_be_i        = '0;
    bus.s_req_ready_i = 1'b0;
    bus.s_rsp_valid_i = 1'b0;
    bus.s_rsp_rdata_i = '0;
    man_sel           = '0;
    use_arb           = 1'b0;
    reset_i           = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    neg();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_s_req_valid", 64'(bus.s_req_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.m_req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.m_rsp_valid_o), 64'd0);
    chk("rst_owner", 64'(owner_o), 64'd0);
    chk("rst_s_addr", 64'(bus.s_addr_o), 64'd0);
    chk("rst_err", 64'(err_spurious_rsp_o), 64'd0);
    tick();

    // Single read from master 1
    set_m(1, 32'h1000, 32'h0, 1'b0, 4'hF);
    bus.m_req_valid_i = 2'b10;
    man_sel = 2'd1;
    grant_q.push_back(2'b10);
    sreq_q.push_back(sreq_t'{32'h1000, 32'h0, 1'b0, 4'hF});
    neg(); tick();
    bus.s_req_ready_i = 1'b1;
    neg();
    chk("rd_s_addr", 64'(bus.s_addr_o), 64'h1000);
    chk("rd_arb_list_req", 64'(arb_valid_list_o), 64'd0);
    chk("rd_owner", 64'(owner_o), 64'd1);
    tick();
    bus.s_req_ready_i = 1'b0;
    neg();
    chk("rd_arb_list_resp", 64'(arb_valid_list_o), 64'd0);
    chk("rd_s_req_valid_resp", 64'(bus.s_req_valid_o), 64'd0);
    tick();
    bus.m_req_valid_i = '0;
    bus.s_rsp_valid_i = 1'b1;
    bus.s_rsp_rdata_i = 32'hDEADBEEF;
    rsp_q.push_back(rsp_t'{2'b10, 32'hDEADBEEF});
    neg(); tick();
    bus.s_rsp_valid_i = 1'b0;
    neg();
    chk("rd_idle_after", 64'(busy_o), 64'd0);
    tick();

    // Back-to-back contention through the round-robin arbiter
    set_m(0, 32'hA000, 32'h0A0A0A0A, 1'b0, 4'hF);
    set_m(1, 32'hB000, 32'h0B0B0B0B, 1'b1, 4'hC);
    bus.m_req_valid_i = 2'b11;
    use_arb = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) begin
        grant_q.push_back(2'b01);
        sreq_q.push_back(sreq_t'{32'hA000, 32'h0A0A0A0A, 1'b0, 4'hF});
      end else begin
        grant_q.push_back(2'b10);
        sreq_q.push_back(sreq_t'{32'hB000, 32'h0B0B0B0B, 1'b1, 4'hC});
      end
      bus.s_req_ready_i = 1'b0;
      bus.s_rsp_valid_i = 1'b0;
      neg(); tick();
      bus.s_req_ready_i = 1'b1;
      neg();
      chk("rr_list_req", 64'(arb_valid_list_o), 64'd0);
      chk("rr_owner", 64'(owner_o), 64'(t % 2));
      tick();
      bus.s_req_ready_i = 1'b0;
      bus.s_rsp_valid_i = 1'b1;
      bus.s_rsp_rdata_i = 32'h100 + 32'(t);
      rsp_q.push_back(rsp_t'{(t % 2 == 0) ? 2'b01 : 2'b10, 32'h100 + 32'(t)});
      neg();
      chk("rr_list_resp", 64'(arb_valid_list_o), 64'd0);
      tick();
    end
    bus.s_rsp_valid_i = 1'b0;
    bus.m_req_valid_i = '0;
    use_arb = 1'b0;
    neg(); tick();

    // Slave backpressure while the master keeps changing its address
    set_m(0, 32'h2000, 32'hCAFE0000, 1'b0, 4'hF);
    bus.m_req_valid_i = 2'b01;
    man_sel = 2'd0;
    grant_q.push_back(2'b01);
    sreq_q.push_back(sreq_t'{32'h2000, 32'hCAFE0000, 1'b0, 4'hF});
    neg(); tick();
    bus.m_req_valid_i = '0;
    for (int c = 0; c < 5; c++) begin
      set_m(0, 32'h3000 + 32'(c), 32'h1111_0000 + 32'(c), 1'b1, 4'h1);
      neg();
      chk("bp_s_addr", 64'(bus.s_addr_o), 64'h2000);
      chk("bp_s_valid", 64'(bus.s_req_valid_o), 64'd1);
      tick();
    end
    bus.s_req_ready_i = 1'b1;
    neg(); tick();
    bus.s_req_ready_i = 1'b0;
    bus.s_rsp_valid_i = 1'b1;
    bus.s_rsp_rdata_i = 32'h55;
    rsp_q.push_back(rsp_t'{2'b01, 32'h55});
    neg(); tick();
    bus.s_rsp_valid_i = 1'b0;

    // Write with partial byte enables
    set_m(1, 32'h40, 32'h12345678, 1'b1, 4'b0011);
    bus.m_req_valid_i = 2'b10;
    man_sel = 2'd1;
    grant_q.push_back(2'b10);
    sreq_q.push_back(sreq_t'{32'h40, 32'h12345678, 1'b1, 4'b0011});
    neg(); tick();
    bus.m_req_valid_i = '0;
    bus.s_req_ready_i = 1'b1;
    neg();
    chk("wr_be", 64'(bus.s_be_o), 64'h3);
    chk("wr_we", 64'(bus.s_we_o), 64'd1);
    tick();
    bus.s_req_ready_i = 1'b0;
    neg();
    chk("wr_wait_busy", 64'(busy_o), 64'd1);
    tick();
    bus.s_rsp_valid_i = 1'b1;
    bus.s_rsp_rdata_i = 32'h0;
    rsp_q.push_back(rsp_t'{2'b10, 32'h0});
    neg(); tick();
    bus.s_rsp_valid_i = 1'b0;
    neg();
    chk("wr_idle", 64'(busy_o), 64'd0);
    chk("wr_single_pulse", 64'(bus.m_rsp_valid_o), 64'd0);
    tick();

    // Spurious response in IDLE
    bus.s_rsp_valid_i = 1'b1;
    bus.s_rsp_rdata_i = 32'hBAD;
    err_q.push_back(1'b1);
    neg();
    chk("sp_busy", 64'(busy_o), 64'd0);
    chk("sp_rsp_valid", 64'(bus.m_rsp_valid_o), 64'd0);
    tick();
    bus.s_rsp_valid_i = 1'b0;
    neg();
    chk("sp_idle_after", 64'(busy_o), 64'd0);
    chk("sp_err_once", 64'(err_spurious_rsp_o), 64'd0);
    tick();

    // Illegal selections: out of range, and pointing at an idle master
    bus.m_req_valid_i = 2'b11;
    man_sel = 2'd2;
    neg();
    chk("ill_range_ready", 64'(bus.m_req_ready_o), 64'd0);
    tick();
    neg();
    chk("ill_range_busy", 64'(busy_o), 64'd0);
    tick();
    bus.m_req_valid_i = 2'b10;
    man_sel = 2'd0;
    neg();
    chk("ill_idle_ready", 64'(bus.m_req_ready_o), 64'd0);
    tick();
    neg();
    chk("ill_idle_busy", 64'(busy_o), 64'd0);
    tick();
    bus.m_req_valid_i = '0;

    // Reset while waiting for the response
    set_m(0, 32'h88, 32'h77, 1'b0, 4'hF);
    bus.m_req_valid_i = 2'b01;
    man_sel = 2'd0;
    grant_q.push_back(2'b01);
    sreq_q.push_back(sreq_t'{32'h88, 32'h77, 1'b0, 4'hF});
    neg(); tick();
    bus.m_req_valid_i = '0;
    bus.s_req_ready_i = 1'b1;
    neg(); tick();
    bus.s_req_ready_i = 1'b0;
    reset_i = 1'b1;
    neg();
    chk("rs_busy_in_resp", 64'(busy_o), 64'd1);
    tick();
    reset_i = 1'b0;
    neg();
    chk("rs_busy", 64'(busy_o), 64'd0);
    chk("rs_s_req_valid", 64'(bus.s_req_valid_o), 64'd0);
    chk("rs_s_addr", 64'(bus.s_addr_o), 64'd0);
    chk("rs_rsp_valid", 64'(bus.m_rsp_valid_o), 64'd0);
    tick();
    neg(); tick();
    bus.s_rsp_valid_i = 1'b1;
    bus.s_rsp_rdata_i = 32'h99;
    err_q.push_back(1'b1);
    neg();
    chk("rs_stale_rsp_valid", 64'(bus.m_rsp_valid_o), 64'd0);
    tick();
    bus.s_rsp_valid_i = 1'b0;
    neg(); tick();

    neg();
    chk("grant_q_empty", 64'(grant_q.size()), 64'd0);
    chk("sreq_q_empty", 64'(sreq_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    chk("err_q_empty", 64'(err_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_request_router.md
Name: bus_request_router

Overview:
- Sits directly downstream of `interface_arbiter`.
- Takes the arbiter's `sel` output and latches the winning master's request into a holding register.
- Drives that request onto a single shared slave port and routes the slave's response back to the owning master.
- Holds ownership until the response returns, so only one transaction is outstanding at a time.

Parameters:
- IN_COUNT, 2, number of requesting masters; must match the arbiter's IN_COUNT.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- m_req_valid_i  in  IN_COUNT  per-master request valid.
- m_req_ready_o  out  IN_COUNT  per-master request accept; one-hot or zero.
- m_addr_i  in  IN_COUNT*ADDR_W  packed addresses; master k at [k*ADDR_W +: ADDR_W].
- m_wdata_i  in  IN_COUNT*DATA_W  packed write data.
- m_we_i  in  IN_COUNT  write enable per master.
- m_be_i  in  IN_COUNT*DATA_W/8  packed byte enables.
- m_rsp_valid_o  out  IN_COUNT  one-cycle response pulse to the owner.
- m_rsp_rdata_o  out  DATA_W  response data, broadcast to all masters; qualified by m_rsp_valid_o.
- arb_valid_list_o  out  IN_COUNT  request list fed to the arbiter's valid_list_i.
- arb_sel_i  in  $clog2(IN_COUNT)+1  arbiter sel_o.
- s_req_valid_o  out  1  slave request valid.
- s_req_ready_i  in  1  slave request accept.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_we_o  out  1  slave write enable.
- s_be_o  out  DATA_W/8  slave byte enables.
- s_rsp_valid_i  in  1  slave response valid; every request, read or write, gets exactly one.
- s_rsp_rdata_i  in  DATA_W  slave response data.
- busy_o  out  1  high whenever state is not IDLE.
- owner_o  out  $clog2(IN_COUNT)  index of the current owner.
- err_spurious_rsp_o  out  1  one-cycle pulse when s_rsp_valid_i arrives outside RESP.

Behaviour:
- FSM states: IDLE, REQ, RESP.
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - owner and holding registers 0.
- arb_valid_list_o:
  - Equals m_req_valid_i in IDLE, 0 in every other state.
  - Reason: the arbiter's round-robin history advances only on cycles where a grant is actually taken.
- IDLE:
  - Grant is legal when |m_req_valid_i, arb_sel_i < IN_COUNT, and m_req_valid_i[arb_sel_i] = 1.
  - On a legal grant:
    - m_req_ready_o[arb_sel_i] = 1 combinationally in the same cycle.
    - Capture owner, addr, wdata, we and be into holding registers.
    - Next state = REQ.
  - Otherwise: stay in IDLE, all m_req_ready_o = 0.
- REQ:
  - s_req_valid_o = 1; s_* fields come from the holding registers and are stable.
  - On s_req_ready_i: next state = RESP.
  - Otherwise hold.
- RESP:
  - Wait for s_rsp_valid_i.
  - When it arrives, in the same cycle:
    - m_rsp_valid_o[owner] = 1 and m_rsp_rdata_o = s_rsp_rdata_i (combinational pass-through).
    - Next state = IDLE.
- Latency: grant in cycle 0, s_req_valid_o high in cycle 1. Minimum turnaround is 3 cycles from grant to the next grant (grant, REQ, RESP with s_rsp_valid_i already high).
- s_rsp_valid_i in IDLE or REQ: pulse err_spurious_rsp_o for one cycle, ignore the data, state unchanged. This covers a response in the same cycle as s_req_ready_i.
- Request inputs are sampled only at the grant. Changes to m_* inputs after acceptance have no effect.
- reset_i asserted mid-transaction:
  - Next cycle: state = IDLE, s_req_valid_o = 0, no m_rsp_valid_o pulse.
  - A later stale slave response is flagged as spurious.
- m_rsp_valid_o is never asserted on more than one bit.

Decomposition:
- Package bus_router_pkg:
  - State enum router_state_e {IDLE, REQ, RESP}.
  - Struct bus_req_t {addr, wdata, we, be}, parameterised by localparams ADDR_W/DATA_W defaults.
  - Function `legal_grant(valid, sel)`.
- No sub-module. The arbiter is instantiated beside this block by the parent adapter, connected through arb_valid_list_o and arb_sel_i.

Test Plan:
- Single read: master 1 valid, addr 0x1000, we 0, arb_sel_i=1, slave ready in cycle 1, response 0xDEADBEEF in cycle 3 -> m_req_ready_o=2'b10 in cycle 0; s_addr_o=0x1000 in cycle 1; m_rsp_valid_o=2'b10 with rdata 0xDEADBEEF in cycle 3; IDLE in cycle 4.
- Back-to-back contention: both masters continuously valid, arbiter instantiated in the bench -> grants alternate 0,1,0,1 over four transactions; arb_valid_list_o=0 during REQ and RESP.
- Slave backpressure: s_req_ready_i low for 5 cycles, master changes m_addr_i meanwhile -> s_addr_o holds the captured address, s_req_valid_o stays high, exactly one handshake.
- Write with byte enables: be=4'b0011, wdata 0x12345678 -> s_be_o=0011, s_we_o=1; ack response delivers one m_rsp_valid_o pulse.
- Spurious and illegal: s_rsp_valid_i in IDLE -> err_spurious_rsp_o pulses and state stays IDLE. arb_sel_i=2 with IN_COUNT=2 -> no grant, m_req_ready_o=0.
- Reset in RESP: reset_i for 1 cycle -> IDLE, no response pulse; slave response 2 cycles later -> err_spurious_rsp_o=1, m_rsp_valid_o=0.
